// File: rtl/arb_mux_pkg.sv
// Shared helpers and constants for the arbitrating N:1 multiplexer.
package arb_mux_pkg;

    localparam bit RESET_DATA = 1'b0;

    // Index width that never collapses to zero bits, even for tiny N.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: scan starts at PTR and wraps modulo N; a single grant is issued when EN is high.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     REQ,
    input  logic [SEL_W-1:0] PTR,
    input  logic             EN,
    output logic [N-1:0]     GNT_ONEHOT,
    output logic [SEL_W-1:0] GNT_IDX,
    output logic             ANY
);

    logic [2*N-1:0] dreq;
    logic [2*N-1:0] masked;
    logic           found;

    // Duplicating the request vector turns the wrap-around scan into a plain lowest-bit search.
    always_comb begin
        dreq    = {REQ, REQ};
        masked  = '0;
        GNT_IDX = '0;
        found   = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            masked[i] = dreq[i] & (i >= int'(PTR));
        end
        for (int i = 0; i < 2 * N; i++) begin
            if (masked[i] && !found) begin
                found   = 1'b1;
                GNT_IDX = (i >= N) ? SEL_W'(i - N) : SEL_W'(i);
            end
        end
        ANY = |REQ;
        GNT_ONEHOT = '0;
        for (int i = 0; i < N; i++) begin
            GNT_ONEHOT[i] = EN & ANY & (GNT_IDX == SEL_W'(i));
        end
    end

endmodule

// File: rtl/arb_mux_nx1.sv
// N:1 arbitrating mux with valid/ready handshakes and one registered output stage.
// Define ARB_MUX_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module arb_mux_nx1
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = clog2_min1(N)
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [N*WIDTH-1:0] IN_DATA,
    input  logic [N-1:0]       IN_VALID,
    output logic [N-1:0]       IN_READY,
    output logic [WIDTH-1:0]   OUT_DATA,
    output logic [SEL_W-1:0]   OUT_SEL,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);

    logic             load_p0;
    logic             any_p0;
    logic             accept_p0;
    logic [N-1:0]     gnt_p0;
    logic [SEL_W-1:0] gnt_idx_p0;
    logic [SEL_W-1:0] ptr;
    logic [WIDTH-1:0] data_p0;
    logic [WIDTH-1:0] data_p1;
    logic [SEL_W-1:0] sel_p1;
    logic             vld_p1;

    // Stage p0: grant and payload select; the slot may refill in the same cycle it drains.
    assign load_p0   = ~vld_p1 | OUT_READY;
    assign accept_p0 = load_p0 & any_p0 & RESET_N;
    assign IN_READY  = gnt_p0;

    rr_arbiter #(.N(N)) u_arb (
        .REQ        (IN_VALID),
        .PTR        (ptr),
        .EN         (load_p0 & RESET_N),
        .GNT_ONEHOT (gnt_p0),
        .GNT_IDX    (gnt_idx_p0),
        .ANY        (any_p0)
    );

    // AND-OR select keeps junk on ungranted channels out of the datapath.
    always_comb begin
        data_p0 = '0;
        for (int i = 0; i < N; i++) begin
            data_p0 = data_p0 | (IN_DATA[i*WIDTH +: WIDTH] & {WIDTH{gnt_p0[i]}});
        end
    end

    // Stage p1: output register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            vld_p1  <= 1'b0;
            data_p1 <= {WIDTH{RESET_DATA}};
            sel_p1  <= '0;
        end else if (load_p0) begin
            vld_p1 <= any_p0;
            if (any_p0) begin
                data_p1 <= data_p0;
                sel_p1  <= gnt_idx_p0;
            end
        end
    end

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // Pointer moves past the winner only on an accepted beat.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ptr <= '0;
        end else if (accept_p0) begin
            ptr <= (gnt_idx_p0 == SEL_W'(N - 1)) ? '0 : gnt_idx_p0 + 1'b1;
        end
    end
`endif

    assign OUT_DATA  = data_p1;
    assign OUT_SEL   = sel_p1;
    assign OUT_VALID = vld_p1;

endmodule
